// File: rtl/onehot_scan_encoder.sv
// onehot_scan_encoder
// Takes a multi-hot request vector and returns the binary index of each set
// bit, one output beat per bit, lowest first (or highest first when
// MSB_FIRST=1). Each beat carries its ordinal within the vector and a
// last-beat flag. An all-zero vector produces a one-cycle zero_err pulse and
// no beats.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   A producer holds valid and its payload stable until that edge. ready
//   never depends combinationally on valid on the same interface, so
//   in_ready depends only on state and clr, and out_valid depends only on
//   state.
//   in_ready=1 only in IDLE. out_valid=1 only in SCAN. Because of this a new
//   vector is never accepted in the same cycle as the final output beat.
module onehot_scan_encoder #(
  parameter int WIDTH     = 32,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W-1:0] out_seq,
  output logic             out_last,
  output logic             zero_err,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_nxt;
  logic [WIDTH-1:0] pick;        // one-hot mask of the bit being presented
  logic [IDX_W-1:0] pick_idx;    // binary position of that bit
  logic [IDX_W-1:0] seq;
  logic [IDX_W-1:0] seq_nxt;
  logic             zero_err_nxt;
  logic             single;      // pending holds exactly one set bit

  // Priority pick. The last match in the loop wins, so the loop runs toward
  // the bit that should have priority.
  if (MSB_FIRST != 0) begin : g_msb_first
    // Highest set bit wins: scan upward so the top match is kept.
    always_comb begin
      pick     = '0;
      pick_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (pending[i]) begin
          pick     = '0;
          pick[i]  = 1'b1;
          pick_idx = IDX_W'(i);
        end
      end
    end
  end else begin : g_lsb_first
    // Lowest set bit wins: scan downward so the bottom match is kept.
    always_comb begin
      pick     = '0;
      pick_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending[i]) begin
          pick     = '0;
          pick[i]  = 1'b1;
          pick_idx = IDX_W'(i);
        end
      end
    end
  end

  // Exactly one bit left: non-zero and clearing the lowest bit gives zero.
  always_comb begin
    single = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
  end

  // Handshake and beat outputs. All beat fields read 0 outside SCAN, and
  // in_ready is forced low while clr is held.
  always_comb begin
    in_ready  = (state == IDLE) && !clr;
    out_valid = (state == SCAN);
    out_index = out_valid ? pick_idx : '0;
    out_seq   = out_valid ? seq : '0;
    out_last  = out_valid && single;
    state_dbg = state;
  end

  // Next-state logic: accept in IDLE, then retire one bit per consumed beat in SCAN.
  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    seq_nxt      = seq;
    zero_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_vec == '0) begin
            zero_err_nxt = 1'b1;
          end else begin
            pending_nxt = in_vec;
            seq_nxt     = '0;
            state_nxt   = SCAN;
          end
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_nxt = pending & ~pick;
          if (single) begin
            // Last beat of this vector. Park seq at 0 so it never wraps.
            seq_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            seq_nxt = seq + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
        seq_nxt     = '0;
      end
    endcase
  end

  // State registers. clr clears them asynchronously and discards any
  // unfinished vector.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      pending  <= '0;
      seq      <= '0;
      zero_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      seq      <= seq_nxt;
      zero_err <= zero_err_nxt;
    end
  end

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Testbench for onehot_scan_encoder. It runs an LSB-first instance and an
// MSB-first instance side by side from shared stimulus. The expected beats
// come from a list of the set-bit positions of each accepted vector.
module tb_onehot_scan_encoder;

  // Clock and reset
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic        in_valid;
  logic [31:0] in_vec;
  logic        out_ready;

  logic       in_ready_l, out_valid_l, out_last_l, zero_err_l, state_dbg_l;
  logic [4:0] out_index_l, out_seq_l;
  logic       in_ready_m, out_valid_m, out_last_m, zero_err_m, state_dbg_m;
  logic [4:0] out_index_m, out_seq_m;

  onehot_scan_encoder #(.WIDTH(32), .MSB_FIRST(0)) dut_l (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_index(out_index_l), .out_seq(out_seq_l), .out_last(out_last_l),
    .zero_err(zero_err_l), .state_dbg(state_dbg_l)
  );

  onehot_scan_encoder #(.WIDTH(32), .MSB_FIRST(1)) dut_m (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_index(out_index_m), .out_seq(out_seq_m), .out_last(out_last_m),
    .zero_err(zero_err_m), .state_dbg(state_dbg_m)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: ascending list of set-bit positions of the current vector.
  int asc[$];

  // Legacy 32-to-5 encoder for one-hot inputs: index bit b is the OR of
  // every request line whose position has bit b set.
  function automatic logic [4:0] legacy_enc(input logic [31:0] v);
    logic [4:0] r;
    for (int b = 0; b < 5; b++) begin
      r[b] = 1'b0;
      for (int p = 0; p < 32; p++) begin
        if ((((p >> b) & 1) == 1) && v[p]) r[b] = 1'b1;
      end
    end
    return r;
  endfunction

  // Driver and checker for one vector. mode: 0 = out_ready always 1,
  // 1 = toggle 1,0,1,0, other = random. garbage drives random in_valid and
  // in_vec while the vector is being scanned.
  task automatic run_vec(input logic [31:0] v, input int mode, input bit garbage);
    int k, j, cyc;
    logic [4:0] el, em, es;
    logic last_e;
    total++;
    if (in_ready_l !== 1'b1 || in_ready_m !== 1'b1) begin
      bad++;
      $display("FAIL ready_before vec=%h got l=%b m=%b exp 1", v, in_ready_l, in_ready_m);
    end
    in_valid  = 1'b1;
    in_vec    = v;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec   = $urandom;
    asc.delete();
    for (int b = 0; b < 32; b++) if (v[b]) asc.push_back(b);
    k = asc.size();
    if (k == 0) begin
      total++;
      if ({zero_err_l, zero_err_m, out_valid_l, out_valid_m} !== 4'b1100) begin
        bad++;
        $display("FAIL zero_pulse got zerr=%b%b valid=%b%b exp zerr=11 valid=00",
                 zero_err_l, zero_err_m, out_valid_l, out_valid_m);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({zero_err_l, zero_err_m} !== 2'b00) begin
        bad++;
        $display("FAIL zero_clear got zerr=%b%b exp 00", zero_err_l, zero_err_m);
      end
      return;
    end
    j = 0;
    cyc = 0;
    while (j < k && cyc < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (garbage) begin
        in_valid = 1'($urandom_range(0, 1));
        in_vec   = $urandom;
      end
      el = 5'(asc[j]);
      em = 5'(asc[k-1-j]);
      es = 5'(j);
      last_e = (j == k - 1);
      total++;
      if ({out_valid_l, in_ready_l, out_index_l, out_seq_l, out_last_l} !== {1'b1, 1'b0, el, es, last_e}) begin
        bad++;
        $display("FAIL beat_lsb vec=%h j=%0d got v=%b r=%b idx=%0d seq=%0d last=%b exp v=1 r=0 idx=%0d seq=%0d last=%b",
                 v, j, out_valid_l, in_ready_l, out_index_l, out_seq_l, out_last_l, el, es, last_e);
      end
      total++;
      if ({out_valid_m, in_ready_m, out_index_m, out_seq_m, out_last_m} !== {1'b1, 1'b0, em, es, last_e}) begin
        bad++;
        $display("FAIL beat_msb vec=%h j=%0d got v=%b r=%b idx=%0d seq=%0d last=%b exp v=1 r=0 idx=%0d seq=%0d last=%b",
                 v, j, out_valid_m, in_ready_m, out_index_m, out_seq_m, out_last_m, em, es, last_e);
      end
      @(posedge clk); #1;
      if (out_ready) j++;
      cyc++;
    end
    in_valid = 1'b0;
    if (j < k) begin
      total++;
      bad++;
      $display("FAIL beat_timeout vec=%h got %0d beats exp %0d", v, j, k);
    end
    total++;
    if ({out_valid_l, out_valid_m, in_ready_l, in_ready_m, zero_err_l, zero_err_m,
         out_index_l, out_seq_l, out_last_l, out_index_m, out_seq_m, out_last_m} !== {4'b0011, 2'b00, 22'd0}) begin
      bad++;
      $display("FAIL after_last vec=%h got valid=%b%b ready=%b%b zerr=%b%b idx=%0d/%0d seq=%0d/%0d last=%b%b exp valid=00 ready=11 zerr=00 rest 0",
               v, out_valid_l, out_valid_m, in_ready_l, in_ready_m, zero_err_l, zero_err_m,
               out_index_l, out_index_m, out_seq_l, out_seq_m, out_last_l, out_last_m);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    in_valid = 1'b0;
    in_vec = 32'hFFFF_FFFF;
    out_ready = 1'b0;
    #1;
    total++;
    if ({in_ready_l, out_valid_l, out_index_l, out_seq_l, out_last_l, zero_err_l,
         in_ready_m, out_valid_m, out_index_m, out_seq_m, out_last_m, zero_err_m} !== 28'd0) begin
      bad++;
      $display("FAIL reset_outputs got ready=%b%b valid=%b%b exp all 0", in_ready_l, in_ready_m, out_valid_l, out_valid_m);
    end
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    #1;
    total++;
    if ({in_ready_l, in_ready_m, out_valid_l, out_valid_m} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_release got ready=%b%b valid=%b%b exp ready=11 valid=00",
               in_ready_l, in_ready_m, out_valid_l, out_valid_m);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_vec(32'h0000_0001, 0, 1'b0);
    run_vec(32'h8000_0001, 0, 1'b0);
    run_vec(32'h0001_0010, 0, 1'b0);
  endtask

  task automatic test_walking();
    logic [31:0] v;
    logic [4:0] exp_idx;
    for (int b = 0; b < 32; b++) begin
      v = 32'd1 << b;
      exp_idx = legacy_enc(v);
      in_valid = 1'b1;
      in_vec = v;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if ({out_valid_l, out_index_l, out_seq_l, out_last_l, out_valid_m, out_index_m, out_last_m} !==
          {1'b1, exp_idx, 5'd0, 1'b1, 1'b1, exp_idx, 1'b1}) begin
        bad++;
        $display("FAIL walking bit=%0d got idx=%0d/%0d seq=%0d last=%b%b exp idx=%0d seq=0 last=11",
                 b, out_index_l, out_index_m, out_seq_l, out_last_l, out_last_m, exp_idx);
      end
      @(posedge clk); #1;
      total++;
      if ({in_ready_l, in_ready_m, out_valid_l, out_valid_m} !== 4'b1100) begin
        bad++;
        $display("FAIL walking_done bit=%0d got ready=%b%b valid=%b%b exp ready=11 valid=00",
                 b, in_ready_l, in_ready_m, out_valid_l, out_valid_m);
      end
    end
  endtask

  task automatic test_backpressure();
    run_vec(32'hFFFF_FFFF, 1, 1'b1);
    run_vec(32'hFFFF_FFFF, 2, 1'b0);
  endtask

  task automatic test_zero();
    in_valid = 1'b1;
    in_vec = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if ({zero_err_l, zero_err_m, out_valid_l, out_valid_m, in_ready_l, in_ready_m} !== 6'b110011) begin
        bad++;
        $display("FAIL zero_stream c=%0d got zerr=%b%b valid=%b%b ready=%b%b exp 11 00 11",
                 c, zero_err_l, zero_err_m, out_valid_l, out_valid_m, in_ready_l, in_ready_m);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({zero_err_l, zero_err_m} !== 2'b00) begin
      bad++;
      $display("FAIL zero_stream_end got zerr=%b%b exp 00", zero_err_l, zero_err_m);
    end
    run_vec(32'd0, 0, 1'b0);
  endtask

  task automatic test_reset_midscan();
    in_valid = 1'b1;
    in_vec = 32'h0000_000F;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if ({out_valid_l, out_index_l, out_seq_l, out_valid_m, out_index_m, out_seq_m} !==
        {1'b1, 5'd2, 5'd2, 1'b1, 5'd1, 5'd2}) begin
      bad++;
      $display("FAIL midscan_pre got l idx=%0d seq=%0d m idx=%0d seq=%0d exp l 2/2 m 1/2",
               out_index_l, out_seq_l, out_index_m, out_seq_m);
    end
    clr = 1'b1;
    #1;
    total++;
    if ({out_valid_l, out_valid_m, in_ready_l, in_ready_m, out_index_l, out_index_m, out_last_l, out_last_m} !== 16'd0) begin
      bad++;
      $display("FAIL midscan_clr got valid=%b%b ready=%b%b idx=%0d/%0d exp all 0",
               out_valid_l, out_valid_m, in_ready_l, in_ready_m, out_index_l, out_index_m);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if ({out_valid_l, out_valid_m, in_ready_l, in_ready_m} !== 4'b0011) begin
        bad++;
        $display("FAIL midscan_after c=%0d got valid=%b%b ready=%b%b exp valid=00 ready=11",
                 c, out_valid_l, out_valid_m, in_ready_l, in_ready_m);
      end
      @(posedge clk); #1;
    end
    run_vec(32'h0000_0008, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom & $urandom & $urandom;
        1:       v = $urandom;
        2:       v = (n % 5 == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
        default: v = $urandom | $urandom;
      endcase
      run_vec(v, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_walking();
    test_backpressure();
    test_zero();
    test_reset_midscan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: if the sequence above ever stalls, stop with a FAIL line.
  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish exp finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/onehot_scan_encoder.md
# onehot_scan_encoder

Parametrised, sequential successor to the combinational 32-to-5 bus-select encoder. Accepts an arbitrary (multi-hot) request vector through a valid/ready handshake and emits the binary index of every set bit, one per accepted output beat, in a fixed priority order. It sits between the register-enable and bus-select logic of the datapath, where a vector can carry more than one set bit. The encoder serialises those bits instead of producing an undefined code.

## Interface
Parameters:
- WIDTH, 32: request vector width; legal values are 2 and up, and need not be a power of two.
- IDX_W, $clog2(WIDTH): index width; derived, do not override.
- MSB_FIRST, 0: 0 emits the lowest set bit first; 1 emits the highest set bit first.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset; asynchronous, active-high.
- in_valid  in  1  in_vec is valid this cycle.
- in_ready  out  1  block can accept a vector.
- in_vec  in  WIDTH  request vector; any number of bits may be set.
- out_valid  out  1  out_index is valid.
- out_ready  in  1  consumer accepts the current index.
- out_index  out  IDX_W  binary position of the current set bit.
- out_seq  out  IDX_W  ordinal of this beat within the vector; the first beat is 0.
- out_last  out  1  this beat is the final set bit of the vector.
- zero_err  out  1  one-cycle pulse; an all-zero vector was accepted.

## Operation
Registers:
- state: IDLE or SCAN.
- pending: WIDTH bits.
- seq: IDX_W bits.
- zero_err: 1 bit.

Reset (clr=1):
- Takes effect immediately, without waiting for a clock edge.
- Sets state=IDLE, pending=0, seq=0, zero_err=0.
- All outputs read 0, including in_ready.

IDLE:
- in_ready=1 and out_valid=0.
- Accept occurs when in_valid && in_ready at a clock edge:
  - in_vec==0: zero_err=1 for the next cycle only; state stays IDLE.
  - in_vec!=0: pending<=in_vec, seq<=0, state<=SCAN.

SCAN:
- in_ready=0 and out_valid=1.
- out_index is the position of the lowest set bit of pending, or the highest when MSB_FIRST=1. It is decoded combinationally from pending and zero-extended to IDX_W.
- out_seq=seq.
- out_last=1 when pending has exactly one bit set.
- When out_valid && out_ready at a clock edge:
  - The emitted bit is cleared in pending.
  - seq increments.
  - If out_last, state<=IDLE.
- While out_ready=0, out_index, out_seq and out_last hold stable.

General rules:
- in_vec and in_valid are ignored while state=SCAN.
- A vector with k set bits produces exactly k beats, each index appearing once, in strictly ascending order (MSB_FIRST=0) or strictly descending order (MSB_FIRST=1).
- out_index, out_seq and out_last read 0 whenever out_valid=0.
- seq never wraps: at most WIDTH beats are emitted, so the largest value is WIDTH-1.

## Timing
- Acceptance to output: a vector accepted at edge N gives out_valid=1 in cycle N+1, with the first index presented.
- Full-rate throughput: with out_ready held at 1, one beat per cycle. A k-bit vector holds the block for k cycles after acceptance, and in_ready returns to 1 in the cycle after the last beat.
- Minimum spacing: k+1 cycles between accepted non-zero vectors; all-zero vectors can be accepted every cycle.
- zero_err: high for exactly the one cycle following acceptance of an all-zero vector.
- Simultaneous events: out_ready on the last beat and in_valid in the same cycle do not chain. The new vector is accepted only when in_ready=1, one cycle later.
- Reset mid-scan: any remaining pending bits are discarded. After clr deasserts, the first rising edge sees IDLE with in_ready=1.

## Test plan
- Single bit: in_vec=32'h00000001, out_ready=1 -> one beat with out_index=0, out_seq=0, out_last=1; in_ready=1 on the next cycle.
- Two bits: in_vec=32'h80000001, MSB_FIRST=0 -> beats with index 0 then 31; out_last only on the second beat; out_seq 0 then 1.
- Walking one: each of 32'h00000001 through 32'h80000000 -> a single beat whose index equals the bit position; compare against the legacy 32-to-5 encoding.
- All ones with backpressure: in_vec=32'hFFFFFFFF, out_ready toggling 1,0,1,0 -> 32 beats with indices 0..31 in order; outputs hold while stalled; out_last on index 31 and out_seq=31.
- MSB_FIRST=1 instance: in_vec=32'h00010010 -> index 16 then index 4.
- Zero vector and reset: in_vec=0 -> zero_err high for one cycle and no out_valid. Then load 32'h0000000F and assert clr after 2 beats -> out_valid drops immediately; after release in_ready=1, pending=0, and no further beats appear.
